// File: rtl/alu_op_sequencer_if.sv
// Command, datapath and result signals of the ALU operation sequencer.
// The sequencer connects through the slave modport; upstream/downstream logic uses master.
interface alu_op_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_op;
    logic [3:0]       i_a;
    logic [3:0]       i_b;
    logic [2:0]       o_ctrl;
    logic [3:0]       o_dat_a;
    logic [3:0]       o_dat_b;
    logic [3:0]       i_mux_dat;
    logic             o_valid;
    logic             i_ready;
    logic [3:0]       o_result;
    logic             o_err;
    logic [CNT_W-1:0] o_op_cnt;

    modport slave (
        input  i_valid, i_op, i_a, i_b, i_mux_dat, i_ready,
        output o_ready, o_ctrl, o_dat_a, o_dat_b, o_valid, o_result, o_err, o_op_cnt
    );

    modport master (
        output i_valid, i_op, i_a, i_b, i_mux_dat, i_ready,
        input  o_ready, o_ctrl, o_dat_a, o_dat_b, o_valid, o_result, o_err, o_op_cnt
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one ALU command to the gate-level datapath, waits SETTLE_CYCLES for it to
// propagate, captures the mux output and hands the result downstream.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic [2:0]       r_ctrl;
    logic [3:0]       r_dat_a;
    logic [3:0]       r_dat_b;
    logic [3:0]       r_result;
    logic             r_err;
    logic             r_valid;
    logic [CNT_W-1:0] r_op_cnt;
    logic             w_legal;

    assign w_legal = (bus.i_op <= 3'd4);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.i_valid) w_next = w_legal ? S_SETTLE : S_DONE;
            S_SETTLE: if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE:   if (bus.i_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= 4'd0;
            r_ctrl   <= 3'd0;
            r_dat_a  <= 4'd0;
            r_dat_b  <= 4'd0;
            r_result <= 4'd0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
            r_op_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        r_ctrl  <= bus.i_op;
                        r_dat_a <= bus.i_a;
                        r_dat_b <= bus.i_b;
                        if (w_legal) begin
                            r_cnt <= LP_SETTLE_LOAD;
                        end else begin
                            // Illegal opcodes skip the datapath and report immediately.
                            r_result <= 4'd0;
                            r_err    <= 1'b1;
                            r_valid  <= 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_result <= bus.i_mux_dat;
                        r_err    <= 1'b0;
                        r_valid  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (bus.i_ready) begin
                        r_valid  <= 1'b0;
                        r_op_cnt <= r_op_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready  = (r_state == S_IDLE);
    assign bus.o_ctrl   = r_ctrl;
    assign bus.o_dat_a  = r_dat_a;
    assign bus.o_dat_b  = r_dat_b;
    assign bus.o_result = r_result;
    assign bus.o_err    = r_err;
    assign bus.o_valid  = r_valid;
    assign bus.o_op_cnt = r_op_cnt;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a small model of the gate-level mux feeds
// i_mux_dat, and expected results are queued on accept and compared on handshake.
module tb_alu_op_sequencer;
    typedef struct packed {
        logic       err;
        logic [3:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.CNT_W(8)) bus ();
    alu_op_sequencer_if #(.CNT_W(8)) bus1 ();

    alu_op_sequencer #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1.slave)
    );

    // Model of the datapath: 0 and, 1 or, 2 add, 3 sub, 4 xor.
    function automatic logic [3:0] mux_model(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return a ^ b;
            default: return 4'hF;
        endcase
    endfunction

    assign bus.i_mux_dat  = mux_model(bus.o_ctrl, bus.o_dat_a, bus.o_dat_b);
    assign bus1.i_mux_dat = mux_model(bus1.o_ctrl, bus1.o_dat_a, bus1.o_dat_b);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t expect_of(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
        exp_t e;
        if (op <= 3'd4) begin
            e.err = 1'b0;
            e.res = mux_model(op, a, b);
        end else begin
            e.err = 1'b1;
            e.res = 4'd0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.i_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", 32'(bus.o_result), 32'(e.res));
                check("sb_err", 32'(bus.o_err), 32'(e.err));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    // Drives a command and returns 1 ns after its accept edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic rdy;
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = bus.o_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                sb.push_back(expect_of(op, a, b));
                bus.i_valid = 1'b0;
                return;
            end
        end
        bus.i_valid = 1'b0;
        check("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.o_valid && bus.i_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] cnt0;

        bus.i_valid  = 1'b0;
        bus.i_op     = 3'd0;
        bus.i_a      = 4'd0;
        bus.i_b      = 4'd0;
        bus.i_ready  = 1'b1;
        bus1.i_valid = 1'b0;
        bus1.i_op    = 3'd0;
        bus1.i_a     = 4'd0;
        bus1.i_b     = 4'd0;
        bus1.i_ready = 1'b1;

        // Reset state
        #3;
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_err", 32'(bus.o_err), 32'd0);
        check("rst_result", 32'(bus.o_result), 32'd0);
        check("rst_ctrl", 32'(bus.o_ctrl), 32'd0);
        check("rst_dat_a", 32'(bus.o_dat_a), 32'd0);
        check("rst_dat_b", 32'(bus.o_dat_b), 32'd0);
        check("rst_op_cnt", 32'(bus.o_op_cnt), 32'd0);
        do_reset();

        // Directed op 2 (9 + 3 = C): latency and latching
        issue(3'd2, 4'h9, 4'h3);
        check("t1_ctrl", 32'(bus.o_ctrl), 32'd2);
        check("t1_dat_a", 32'(bus.o_dat_a), 32'h9);
        check("t1_dat_b", 32'(bus.o_dat_b), 32'h3);
        check("t1_ready_t0", 32'(bus.o_ready), 32'd0);
        check("t1_valid_t0", 32'(bus.o_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_ready_t1", 32'(bus.o_ready), 32'd0);
        check("t1_valid_t1", 32'(bus.o_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_t2", 32'(bus.o_valid), 32'd1);
        check("t1_result_t2", 32'(bus.o_result), 32'hC);
        check("t1_err_t2", 32'(bus.o_err), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_t3", 32'(bus.o_valid), 32'd0);
        check("t1_cnt_t3", 32'(bus.o_op_cnt), 32'd1);

        // Sweep every legal opcode with random operands
        do_reset();
        for (int op = 0; op < 5; op++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            issue(3'(op), a, b);
            wait_done();
        end
        check("sweep_cnt", 32'(bus.o_op_cnt), 32'd5);
        check("sweep_sb_empty", 32'(sb.size()), 32'd0);

        // Illegal opcode with downstream stall
        do_reset();
        bus.i_ready = 1'b0;
        issue(3'd6, 4'h5, 4'hA);
        for (int i = 0; i < 4; i++) begin
            check("ill_valid", 32'(bus.o_valid), 32'd1);
            check("ill_err", 32'(bus.o_err), 32'd1);
            check("ill_result", 32'(bus.o_result), 32'd0);
            check("ill_cnt_hold", 32'(bus.o_op_cnt), 32'd0);
            @(posedge clk); #1;
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        check("ill_valid_drop", 32'(bus.o_valid), 32'd0);
        check("ill_cnt_inc", 32'(bus.o_op_cnt), 32'd1);
        check("ill_ready", 32'(bus.o_ready), 32'd1);

        // Asynchronous reset during SETTLE
        do_reset();
        issue(3'd1, 4'h6, 4'h9);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_ready", 32'(bus.o_ready), 32'd1);
        check("arst_valid", 32'(bus.o_valid), 32'd0);
        check("arst_ctrl", 32'(bus.o_ctrl), 32'd0);
        check("arst_dat_a", 32'(bus.o_dat_a), 32'd0);
        check("arst_dat_b", 32'(bus.o_dat_b), 32'd0);
        check("arst_result", 32'(bus.o_result), 32'd0);
        check("arst_err", 32'(bus.o_err), 32'd0);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_valid", 32'(bus.o_valid), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("arst_post_valid", 32'(bus.o_valid), 32'd0);
        end
        check("arst_cnt", 32'(bus.o_op_cnt), 32'd0);

        // i_valid held high with operands changing every cycle
        begin
            logic       rdy;
            logic [2:0] acc_op;
            logic [3:0] acc_a;
            logic [3:0] acc_b;
            int         last_acc;
            int         n_acc;
            acc_op   = 3'd0;
            acc_a    = 4'd0;
            acc_b    = 4'd0;
            last_acc = -1;
            n_acc    = 0;
            do_reset();
            bus.i_valid = 1'b1;
            bus.i_op    = 3'($urandom_range(0, 4));
            bus.i_a     = 4'($urandom_range(0, 15));
            bus.i_b     = 4'($urandom_range(0, 15));
            for (int cyc = 0; cyc < 40; cyc++) begin
                @(negedge clk);
                rdy = bus.o_ready;
                @(posedge clk); #1;
                if (rdy) begin
                    acc_op = bus.i_op;
                    acc_a  = bus.i_a;
                    acc_b  = bus.i_b;
                    sb.push_back(expect_of(acc_op, acc_a, acc_b));
                    if (last_acc >= 0) check("cont_gap", 32'(cyc - last_acc), 32'd4);
                    last_acc = cyc;
                    n_acc++;
                end
                check("cont_ctrl", 32'(bus.o_ctrl), 32'(acc_op));
                check("cont_dat_a", 32'(bus.o_dat_a), 32'(acc_a));
                check("cont_dat_b", 32'(bus.o_dat_b), 32'(acc_b));
                bus.i_op = 3'($urandom_range(0, 4));
                bus.i_a  = 4'($urandom_range(0, 15));
                bus.i_b  = 4'($urandom_range(0, 15));
            end
            bus.i_valid = 1'b0;
            check("cont_accepts", 32'(n_acc), 32'd10);
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (bus.o_ready && !bus.o_valid) break;
            end
            @(negedge clk);
            check("cont_sb_empty", 32'(sb.size()), 32'd0);
        end

        // Counter wrap over 256 handshakes
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            cnt0 = bus.o_op_cnt;
            issue(3'($urandom_range(0, 4)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            wait_done();
            check("wrap_step", 32'(bus.o_op_cnt), 32'(8'(cnt0 + 8'd1)));
            if (n == 255) check("wrap_255", 32'(bus.o_op_cnt), 32'd255);
        end
        check("wrap_0", 32'(bus.o_op_cnt), 32'd0);

        // SETTLE_CYCLES = 1 instance: result valid one edge after accept
        @(posedge clk); #1;
        bus1.i_valid = 1'b1;
        bus1.i_op    = 3'd3;
        bus1.i_a     = 4'h5;
        bus1.i_b     = 4'h7;
        check("s1_ready", 32'(bus1.o_ready), 32'd1);
        @(posedge clk); #1;
        bus1.i_valid = 1'b0;
        check("s1_valid_t0", 32'(bus1.o_valid), 32'd0);
        check("s1_ctrl_t0", 32'(bus1.o_ctrl), 32'd3);
        @(posedge clk); #1;
        check("s1_valid_t1", 32'(bus1.o_valid), 32'd1);
        check("s1_result_t1", 32'(bus1.o_result), 32'hE);
        check("s1_err_t1", 32'(bus1.o_err), 32'd0);
        @(posedge clk); #1;
        check("s1_valid_t2", 32'(bus1.o_valid), 32'd0);
        check("s1_cnt_t2", 32'(bus1.o_op_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
